// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Captures decoded operands, register specifiers and control bits from ID and
// presents them to EX. When a load sitting in EX writes a register read by the
// instruction in ID, ID is stalled and LOAD_USE_BUBBLES bubbles are inserted.
// A branch flush kills the ID->EX transfer. A memory stall freezes the whole
// register.
//
// Optional feature macro: ID_EX_STATS_EN adds saturating 32-bit bubble and
// flush counters. When it is undefined, both statistics outputs are tied to 0.
//
// Ports:
//   clk, reset                      clock; synchronous active-low reset
//   inValidId                       ID holds a real instruction
//   inRegisterRs/Rt/RdId            ID register specifiers
//   inRegWriteId, inMemReadId       ID control bits
//   inDataAId, inDataBId, inImmId   ID operands
//   inFlush                         branch taken in EX; load a bubble
//   inStallMem                      memory stall; hold everything
//   outStallId                      hold PC and IF/ID (combinational)
//   outValidEx ... outImmEx         registered EX-stage fields
//   outBubbleCount, outFlushCount   statistics
module id_ex_stage_reg #(
  parameter int unsigned BUS_DATA_WIDTH   = 64,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValidId,
  input  logic [REG_ADDR_WIDTH-1:0] inRegisterRsId,
  input  logic [REG_ADDR_WIDTH-1:0] inRegisterRtId,
  input  logic [REG_ADDR_WIDTH-1:0] inRegisterRdId,
  input  logic                      inRegWriteId,
  input  logic                      inMemReadId,
  input  logic [BUS_DATA_WIDTH-1:0] inDataAId,
  input  logic [BUS_DATA_WIDTH-1:0] inDataBId,
  input  logic [BUS_DATA_WIDTH-1:0] inImmId,
  input  logic                      inFlush,
  input  logic                      inStallMem,
  output logic                      outStallId,
  output logic                      outValidEx,
  output logic [REG_ADDR_WIDTH-1:0] outRegisterRsEx,
  output logic [REG_ADDR_WIDTH-1:0] outRegisterRtEx,
  output logic [REG_ADDR_WIDTH-1:0] outRegisterRdEx,
  output logic                      outRegWriteEx,
  output logic                      outMemReadEx,
  output logic [BUS_DATA_WIDTH-1:0] outDataAEx,
  output logic [BUS_DATA_WIDTH-1:0] outDataBEx,
  output logic [BUS_DATA_WIDTH-1:0] outImmEx,
  output logic [31:0]               outBubbleCount,
  output logic [31:0]               outFlushCount
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [1:0] CntInit = 2'(LOAD_USE_BUBBLES - 1);

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic                      reg_write_q, reg_write_d;
  logic                      mem_read_q, mem_read_d;
  logic [BUS_DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d, imm_q, imm_d;

  logic hazard;
  logic bubble_ins;  // a load-use bubble enters EX on this edge

  assign hazard = valid_q & mem_read_q & (rd_q != '0) & inValidId &
                  ((rd_q == inRegisterRsId) | (rd_q == inRegisterRtId));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      imm_q       <= imm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    imm_d       = imm_q;
    bubble_ins  = 1'b0;

    if (inFlush || inStallMem || state_q == StStall || hazard) begin
      // Bubble: control and specifiers cleared, operands left as don't-care.
      if (!inStallMem || inFlush) begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
      end
      if (inFlush) begin
        state_d = StRun;
        cnt_d   = '0;
      end else if (inStallMem) begin
        // Freeze: the defaults already hold every register.
      end else if (state_q == StStall) begin
        bubble_ins = 1'b1;
        cnt_d      = cnt_q - 2'd1;
        state_d    = (cnt_q == 2'd1) ? StRun : StStall;
      end else begin
        bubble_ins = 1'b1;
        cnt_d      = CntInit;
        state_d    = (LOAD_USE_BUBBLES > 1) ? StStall : StRun;
      end
    end else begin
      valid_d     = inValidId;
      rs_d        = inRegisterRsId;
      rt_d        = inRegisterRtId;
      rd_d        = inRegisterRdId;
      reg_write_d = inRegWriteId;
      mem_read_d  = inMemReadId;
      data_a_d    = inDataAId;
      data_b_d    = inDataBId;
      imm_d       = inImmId;
    end
  end

  // Output logic
  always_comb begin
    outStallId = 1'b0;
    if (inFlush) begin
      outStallId = 1'b0;
    end else if (inStallMem) begin
      outStallId = 1'b1;
    end else begin
      outStallId = (state_q == StStall) | hazard;
    end
  end

  assign outValidEx      = valid_q;
  assign outRegisterRsEx = rs_q;
  assign outRegisterRtEx = rt_q;
  assign outRegisterRdEx = rd_q;
  assign outRegWriteEx   = reg_write_q;
  assign outMemReadEx    = mem_read_q;
  assign outDataAEx      = data_a_q;
  assign outDataBEx      = data_b_q;
  assign outImmEx        = imm_q;

`ifdef ID_EX_STATS_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  // A flush wins over a memory stall, so a flush cycle is counted even then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bubble_ins && bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (inFlush && flush_cnt_q != '1)     flush_cnt_q  <= flush_cnt_q + 32'd1;
    end
  end

  assign outBubbleCount = bubble_cnt_q;
  assign outFlushCount  = flush_cnt_q;
`else
  logic unused_bubble_ins;
  assign unused_bubble_ins = bubble_ins;
  assign outBubbleCount    = '0;
  assign outFlushCount     = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: one instance with 1 bubble per load-use
// hazard (u1) and one with 3 (u3), driven by the same ID-side stimulus.
module tb_id_ex_stage_reg;

`ifdef ID_EX_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_rw, in_mr;
  logic [63:0] in_a, in_b, in_imm;
  logic        in_flush, in_stall_mem;

  logic        st1, v1, rw1, mr1;
  logic [4:0]  rs1, rt1, rd1;
  logic [63:0] a1, b1, imm1;
  logic [31:0] bc1, fc1;
  logic        st3, v3, rw3, mr3;
  logic [4:0]  rs3, rt3, rd3;
  logic [63:0] a3, b3, imm3;
  logic [31:0] bc3, fc3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.LOAD_USE_BUBBLES(1)) u1 (
    .clk(clk), .reset(reset), .inValidId(in_valid),
    .inRegisterRsId(in_rs), .inRegisterRtId(in_rt), .inRegisterRdId(in_rd),
    .inRegWriteId(in_rw), .inMemReadId(in_mr),
    .inDataAId(in_a), .inDataBId(in_b), .inImmId(in_imm),
    .inFlush(in_flush), .inStallMem(in_stall_mem), .outStallId(st1),
    .outValidEx(v1), .outRegisterRsEx(rs1), .outRegisterRtEx(rt1),
    .outRegisterRdEx(rd1), .outRegWriteEx(rw1), .outMemReadEx(mr1),
    .outDataAEx(a1), .outDataBEx(b1), .outImmEx(imm1),
    .outBubbleCount(bc1), .outFlushCount(fc1)
  );

  id_ex_stage_reg #(.LOAD_USE_BUBBLES(3)) u3 (
    .clk(clk), .reset(reset), .inValidId(in_valid),
    .inRegisterRsId(in_rs), .inRegisterRtId(in_rt), .inRegisterRdId(in_rd),
    .inRegWriteId(in_rw), .inMemReadId(in_mr),
    .inDataAId(in_a), .inDataBId(in_b), .inImmId(in_imm),
    .inFlush(in_flush), .inStallMem(in_stall_mem), .outStallId(st3),
    .outValidEx(v3), .outRegisterRsEx(rs3), .outRegisterRtEx(rt3),
    .outRegisterRdEx(rd3), .outRegWriteEx(rw3), .outMemReadEx(mr3),
    .outDataAEx(a3), .outDataBEx(b3), .outImmEx(imm3),
    .outBubbleCount(bc3), .outFlushCount(fc3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [63:0] a);
    in_valid = v;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_rw    = rw;
    in_mr    = mr;
    in_a     = a;
    in_b     = a ^ 64'hFF;
    in_imm   = a + 64'd1;
    #1;
  endtask

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    in_flush     = 1'b0;
    in_stall_mem = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 64'hDEAD);

    // Reset with nonzero inputs
    tick();
    tick();
    check("rst_valid1", v1, 0);
    check("rst_rd1", rd1, 0);
    check("rst_mr1", mr1, 0);
    check("rst_a1", a1, 0);
    check("rst_imm1", imm1, 0);
    check("rst_stall1", st1, 0);
    check("rst_valid3", v3, 0);
    check("rst_bc1", bc1, 0);
    check("rst_fc1", fc1, 0);

    // First capture
    reset = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 64'h1234);
    tick();
    check("cap_rd", rd1, 5);
    check("cap_a", a1, 64'h1234);
    check("cap_b", b1, 64'h1234 ^ 64'hFF);
    check("cap_imm", imm1, 64'h1235);
    check("cap_valid", v1, 1);
    check("cap_rw", rw1, 1);
    check("cap_rs", rs1, 1);
    check("cap_rt", rt1, 2);

    // Load-use: load Rd=3 in EX, dependent reads Rs=3
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'hAAAA);
    tick();
    check("ld_mr", mr1, 1);
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 64'hBEEF);
    check("lu_stall1", st1, 1);
    check("lu_stall3", st3, 1);
    tick();
    check("lu1_bub_valid", v1, 0);
    check("lu1_bub_rd", rd1, 0);
    check("lu1_bub_rw", rw1, 0);
    check("lu1_stall_off", st1, 0);
    check("lu3_bub1_valid", v3, 0);
    check("lu3_stall_c2", st3, 1);
    tick();
    check("lu1_dep_valid", v1, 1);
    check("lu1_dep_rd", rd1, 6);
    check("lu1_dep_a", a1, 64'hBEEF);
    check("lu1_bc", bc1, Stats ? 64'd1 : 64'd0);
    check("lu3_bub2_valid", v3, 0);
    check("lu3_stall_c3", st3, 1);
    tick();
    check("lu3_bub3_valid", v3, 0);
    check("lu3_stall_off", st3, 0);
    tick();
    check("lu3_dep_valid", v3, 1);
    check("lu3_dep_rd", rd3, 6);
    check("lu3_dep_a", a3, 64'hBEEF);
    check("lu3_bc", bc3, Stats ? 64'd3 : 64'd0);

    // Load with Rd=0 never stalls
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 64'h11);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 64'h22);
    check("rd0_stall1", st1, 0);
    check("rd0_stall3", st3, 0);

    // Invalid ID instruction never stalls
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'h33);
    tick();
    set_id(1'b0, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 64'h44);
    check("inv_stall1", st1, 0);
    check("inv_stall3", st3, 0);
    tick();
    check("inv_valid3", v3, 0);

    // Flush while u3 is in STALL with cnt=2
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'h55);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 64'h66);
    tick();
    check("fl_pre_stall3", st3, 1);
    in_flush = 1'b1;
    #1;
    check("fl_stall_forced_off", st3, 0);
    tick();
    in_flush = 1'b0;
    #1;
    check("fl_bub_valid3", v3, 0);
    check("fl_bub_rd3", rd3, 0);
    check("fl_run_stall3", st3, 0);
    check("fl_fc3", fc3, Stats ? 64'd1 : 64'd0);
    check("fl_bc3", bc3, Stats ? 64'd4 : 64'd0);
    check("fl_bc1", bc1, Stats ? 64'd2 : 64'd0);
    tick();
    check("fl_dep_valid3", v3, 1);
    check("fl_dep_rd3", rd3, 6);

    // Memory stall held 4 cycles mid-capture
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 64'h5555);
    tick();
    in_stall_mem = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b0, 1'b0, 64'h6666);
    check("ms_stall1", st1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ms_hold_rd1", rd1, 9);
      check("ms_hold_a3", a3, 64'h5555);
      check("ms_hold_valid3", v3, 1);
    end
    check("ms_fc_held", fc3, Stats ? 64'd1 : 64'd0);
    in_stall_mem = 1'b0;
    tick();
    check("ms_resume_rd1", rd1, 10);
    check("ms_resume_a1", a1, 64'h6666);
    check("ms_resume_rw1", rw1, 0);

    // Memory stall suppresses a pending hazard; the load stays in EX
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'h77);
    tick();
    in_stall_mem = 1'b1;
    set_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 64'h88);
    tick();
    check("msh_mr3", mr3, 1);
    check("msh_rd3", rd3, 3);
    check("msh_bc1", bc1, Stats ? 64'd2 : 64'd0);

    // Flush and memory stall together: flush wins
    in_flush = 1'b1;
    #1;
    check("fm_stall1", st1, 0);
    tick();
    in_flush     = 1'b0;
    in_stall_mem = 1'b0;
    #1;
    check("fm_valid1", v1, 0);
    check("fm_mr3", mr3, 0);
    check("fm_rd3", rd3, 0);

    // Reset asserted mid-STALL
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 64'h99);
    tick();
    set_id(1'b1, 5'd3, 5'd0, 5'd6, 1'b1, 1'b0, 64'hAA);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rs_valid3", v3, 0);
    check("rs_stall3", st3, 0);
    check("rs_bc3", bc3, 0);
    tick();
    check("rs_cap_rd3", rd3, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register with integrated load-use hazard detection. Sits between decode and execute: captures decoded operands, register specifiers and control bits from ID and presents them to the EX stage, where the forwarding unit consumes the registered Rs/Rt/Rd specifiers. When a load in EX feeds the instruction in ID, the block stalls ID and inserts a configurable number of bubbles. It also honours branch flushes and whole-pipeline memory stalls.

## Interface
- BUS_DATA_WIDTH, 64, operand/immediate width
- REG_ADDR_WIDTH, 5, register specifier width
- LOAD_USE_BUBBLES, 1, bubbles per load-use hazard (legal 1..3)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- inValidId  in  1  ID holds a real instruction
- inRegisterRsId / inRegisterRtId / inRegisterRdId  in  REG_ADDR_WIDTH  ID specifiers
- inRegWriteId / inMemReadId  in  1  ID control bits
- inDataAId / inDataBId / inImmId  in  BUS_DATA_WIDTH  ID operands
- inFlush  in  1  branch taken in EX; kill ID→EX transfer
- inStallMem  in  1  memory stall; freeze this register
- outStallId  out  1  hold PC and IF/ID this cycle (combinational)
- outValidEx  out  1  EX slot valid
- outRegisterRsEx / outRegisterRtEx / outRegisterRdEx  out  REG_ADDR_WIDTH  to EX / forwarding unit
- outRegWriteEx / outMemReadEx  out  1  EX control bits
- outDataAEx / outDataBEx / outImmEx  out  BUS_DATA_WIDTH  EX operands
- outBubbleCount / outFlushCount  out  32  statistics (see Configuration)

## Operation
- States: RUN, STALL; 2-bit bubble counter cnt.
- Hazard H = outValidEx & outMemReadEx & (outRegisterRdEx != 0) & inValidId & (outRegisterRdEx == inRegisterRsId | outRegisterRdEx == inRegisterRtId).
- Bubble = outValidEx, outRegWriteEx, outMemReadEx load 0; specifiers load 0; data/imm fields hold previous value (don't-care).
- Priority per edge: reset > inFlush > inStallMem > stall/bubble > normal capture.
- RUN, no H: capture all ID inputs; outValidEx <= inValidId.
- RUN, H: outStallId=1; bubble loaded; cnt <= LOAD_USE_BUBBLES-1; next = STALL if LOAD_USE_BUBBLES>1 else RUN.
- STALL: outStallId=1; bubble loaded; cnt <= cnt-1; cnt==1 → RUN.
- inFlush (any state): bubble loaded, state <= RUN, cnt <= 0, outStallId=0.
- inStallMem without inFlush: all registers, state, cnt held; outStallId=1 (ID must also hold); H not re-evaluated.
- Invalid ID (inValidId=0) never triggers H.

## Timing
- Reset values: all out*Ex = 0, state RUN, cnt 0, counters 0, outStallId 0.
- Capture latency 1 cycle: ID inputs at edge N appear on out*Ex after edge N.
- outStallId is combinational from registered EX fields, state and ID inputs; valid same cycle as H.
- Load-use: dependent instruction enters EX exactly LOAD_USE_BUBBLES cycles later than it would have without the hazard.
- Reset asserted mid-STALL: next edge returns RUN, cnt 0, EX slot empty.
- inFlush and inStallMem same cycle: flush wins.

## Configuration
- ID_EX_STATS_EN defined: outBubbleCount increments once per load-use bubble inserted; outFlushCount increments once per cycle with inFlush=1; both 32-bit, saturate at 0xFFFF_FFFF, held during inStallMem, cleared by reset.
- Undefined: no counter flops; both outputs tied to 0.

## Test plan
- Reset low 2 cycles with nonzero inputs → all outputs 0, outStallId 0; release, ID Rd=5 RegWrite=1 DataA=0x1234 → next cycle outRegisterRdEx=5, outDataAEx=0x1234, outValidEx=1.
- EX load Rd=3, ID Rs=3, LOAD_USE_BUBBLES=1 → outStallId=1 one cycle, one bubble (outValidEx=0), then dependent instruction in EX; outBubbleCount=1.
- LOAD_USE_BUBBLES=3, same hazard → outStallId high 3 cycles, 3 bubbles, then RUN; load with Rd=0 or ID invalid → no stall.
- inFlush asserted in STALL with cnt=2 → next cycle bubble, RUN, outStallId=0; outFlushCount=1.
- inStallMem held 4 cycles mid-capture → out*Ex and state unchanged, counters unchanged; on release flow resumes. inFlush+inStallMem together → bubble loaded.
- Build without ID_EX_STATS_EN, repeat scenario 2 → outBubbleCount=0, functional behaviour identical.
